exp5_unidade_controle: RTL and testbench



---
 rtl/exp5_unidade_controle_if.sv | 38 +++
 rtl/exp5_unidade_controle.sv | 139 +++++++++++++
 tb/tb_exp5_unidade_controle.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exp5_unidade_controle_if.sv
// ----------------------------------------------------------------------------
// exp5_unidade_controle_if
// Groups the signals exchanged between the exp5 control unit and the datapath
// side (datapath or testbench) into one bundle.
//   Datapath -> unit : iniciar, jogada, fimC, igual
//   Unit -> datapath : zeraC, contaC, zeraR, registraR, pronto, acertou,
//                      errou, timeout, db_estado[3:0]
// Modports:
//   slave  - the control unit: it samples the requests and drives the commands.
//   master - whoever drives iniciar/jogada/fimC/igual and observes the commands.
// ----------------------------------------------------------------------------
interface exp5_unidade_controle_if;
    logic       iniciar;
    logic       jogada;
    logic       fimC;
    logic       igual;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    modport slave (
        input  iniciar, jogada, fimC, igual,
        output zeraC, contaC, zeraR, registraR,
               pronto, acertou, errou, timeout, db_estado
    );

    modport master (
        output iniciar, jogada, fimC, igual,
        input  zeraC, contaC, zeraR, registraR,
               pronto, acertou, errou, timeout, db_estado
    );
endinterface

// File: rtl/exp5_unidade_controle.sv
// ----------------------------------------------------------------------------
// exp5_unidade_controle
// Moore control unit for one "repeat the stored sequence" round of exp5.
// After iniciar it clears the position counter and play register, then for
// every memory position waits for a rising edge of jogada, registers the play,
// looks at the comparator and either advances, finishes with success, finishes
// with an error, or finishes on timeout when no play arrives in time.
// Ports:
//   clock  - system clock, everything on the rising edge
//   reset  - synchronous, active-low (0 = reset)
//   ctrl   - handshake bundle (slave side), see exp5_unidade_controle_if
// Parameter:
//   TIMEOUT_CICLOS - cycles allowed in espera_jogada before a timeout (>= 2)
// ----------------------------------------------------------------------------
module exp5_unidade_controle #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic                    clock,
    input  logic                    reset,
    exp5_unidade_controle_if.slave  ctrl
);

    localparam int TIMER_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CICLOS - 1);

    // State codes double as the HEX5 display value, so they are fixed here
    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARACAO    = 4'h1,
        ESPERA_JOGADA = 4'h2,
        REGISTRA      = 4'h3,
        COMPARACAO    = 4'h4,
        PROXIMO       = 4'h5,
        FIM_ACERTO    = 4'hA,
        FIM_TIMEOUT   = 4'hD,
        FIM_ERRO      = 4'hE
    } estado_t;

    estado_t              estado_q, estado_d;
    logic                 jogada_q;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 jogadaEdge;
    logic                 timerFim;

    logic zeraC, contaC, zeraR, registraR;
    logic pronto, acertou, errou, timeout;

    // A play held high must count once, so only its rising edge is used
    assign jogadaEdge = ctrl.jogada & ~jogada_q;
    assign timerFim   = (timer_q == TIMER_MAX);

    // State register, delayed copy of jogada and wait timer.
    // Reset is synchronous and can abort a round at any point.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= INICIAL;
            jogada_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            estado_q <= estado_d;
            jogada_q <= ctrl.jogada;
            timer_q  <= timer_d;
        end
    end

    // Next-state logic and Moore output decode.
    // The timer only runs in espera_jogada, so it restarts from zero on every
    // entry and each position gets a full window. A play edge in the same
    // cycle as the timer expiry still counts as a play.
    always_comb begin
        estado_d  = estado_q;
        timer_d   = '0;
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado_q)
            INICIAL: begin
                if (ctrl.iniciar) estado_d = PREPARACAO;
            end
            PREPARACAO: begin
                zeraC    = 1'b1;
                zeraR    = 1'b1;
                estado_d = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                timer_d = timer_q + TIMER_W'(1);
                if (jogadaEdge)    estado_d = REGISTRA;
                else if (timerFim) estado_d = FIM_TIMEOUT;
            end
            REGISTRA: begin
                registraR = 1'b1;
                estado_d  = COMPARACAO;
            end
            COMPARACAO: begin
                if (!ctrl.igual)     estado_d = FIM_ERRO;
                else if (ctrl.fimC)  estado_d = FIM_ACERTO;
                else                 estado_d = PROXIMO;
            end
            PROXIMO: begin
                contaC   = 1'b1;
                estado_d = ESPERA_JOGADA;
            end
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
                if (ctrl.iniciar) estado_d = PREPARACAO;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
                if (ctrl.iniciar) estado_d = PREPARACAO;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
                if (ctrl.iniciar) estado_d = PREPARACAO;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    assign ctrl.zeraC     = zeraC;
    assign ctrl.contaC    = contaC;
    assign ctrl.zeraR     = zeraR;
    assign ctrl.registraR = registraR;
    assign ctrl.pronto    = pronto;
    assign ctrl.acertou   = acertou;
    assign ctrl.errou     = errou;
    assign ctrl.timeout   = timeout;
    assign ctrl.db_estado = estado_q;

endmodule

// File: tb/tb_exp5_unidade_controle.sv
// ----------------------------------------------------------------------------
// tb_exp5_unidade_controle
// Self-checking bench for exp5_unidade_controle with TIMEOUT_CICLOS = 8.
// Inputs change after the falling edge, the DUT samples on the rising edge and
// outputs are compared on the next falling edge.
// ----------------------------------------------------------------------------
module tb_exp5_unidade_controle;

    localparam int T = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int nChecks = 0;
    int nErrors = 0;
    int cntRegistra = 0;
    int cntConta = 0;
    int cntZera = 0;

    // Reference model: current round phase (display code), number of cycles
    // already spent waiting for the current play, and last jogada level.
    int mState = 0;
    int mWait = 0;
    bit mJogPrev = 1'b0;

    typedef struct {
        logic       r;
        logic       ini;
        logic       jog;
        logic       fc;
        logic       ig;
        logic [3:0] expState;
        logic [7:0] expOuts;
    } vec_t;

    vec_t vecs[19];

    exp5_unidade_controle_if bus ();

    exp5_unidade_controle #(.TIMEOUT_CICLOS(T)) dut (
        .clock (clock),
        .reset (reset),
        .ctrl  (bus)
    );

    // Free-running 10-unit clock
    always #5 clock = ~clock;

    // Expected output vector {zeraC,contaC,zeraR,registraR,pronto,acertou,errou,timeout}
    function automatic logic [7:0] modelOuts(input int s);
        logic [7:0] o;
        o = 8'h00;
        if (s == 1) begin o[7] = 1'b1; o[5] = 1'b1; end
        if (s == 5) o[6] = 1'b1;
        if (s == 3) o[4] = 1'b1;
        if (s == 10 || s == 13 || s == 14) o[3] = 1'b1;
        if (s == 10) o[2] = 1'b1;
        if (s == 14) o[1] = 1'b1;
        if (s == 13) o[0] = 1'b1;
        return o;
    endfunction

    // Advances the round model by one clock using the rules of the game
    task automatic modelStep(input logic r, ini, jog, fc, ig);
        bit rising;
        int nxt;
        if (!r) begin
            mState = 0;
            mWait = 0;
            mJogPrev = 1'b0;
            return;
        end
        rising = jog && !mJogPrev;
        mJogPrev = jog;
        nxt = mState;
        if (mState == 0 || mState == 10 || mState == 13 || mState == 14) begin
            if (ini) nxt = 1;
        end else if (mState == 1) begin
            nxt = 2;
        end else if (mState == 2) begin
            if (rising) nxt = 3;
            else if (mWait == T) nxt = 13;
        end else if (mState == 3) begin
            nxt = 4;
        end else if (mState == 4) begin
            nxt = !ig ? 14 : (fc ? 10 : 5);
        end else if (mState == 5) begin
            nxt = 2;
        end
        if (nxt == 2) mWait = (mState == 2) ? mWait + 1 : 1;
        else mWait = 0;
        mState = nxt;
    endtask

    // Drives one cycle of inputs, steps the model and tallies command pulses
    task automatic applyStimulus(input logic r, ini, jog, fc, ig);
        reset = r;
        bus.iniciar = ini;
        bus.jogada = jog;
        bus.fimC = fc;
        bus.igual = ig;
        @(posedge clock);
        modelStep(r, ini, jog, fc, ig);
        @(negedge clock);
        if (bus.registraR) cntRegistra++;
        if (bus.contaC) cntConta++;
        if (bus.zeraC) cntZera++;
    endtask

    // Compares state display and all command outputs against expectations
    task automatic checkOutput(input string name, input logic [3:0] expState, input logic [7:0] expOuts);
        logic [7:0] act;
        act = {bus.zeraC, bus.contaC, bus.zeraR, bus.registraR,
               bus.pronto, bus.acertou, bus.errou, bus.timeout};
        nChecks++;
        if (bus.db_estado !== expState || act !== expOuts) begin
            nErrors++;
            $display("[TB] FAIL %s: got estado=%h outs=%b, expected estado=%h outs=%b",
                     name, bus.db_estado, act, expState, expOuts);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic stepCheck(input string name, input logic r, ini, jog, fc, ig);
        applyStimulus(r, ini, jog, fc, ig);
        checkOutput(name, 4'(mState), modelOuts(mState));
    endtask

    // Main test sequence
    initial begin
        int inWait;

        bus.iniciar = 1'b0;
        bus.jogada = 1'b0;
        bus.fimC = 1'b0;
        bus.igual = 1'b0;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'b0000_0000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'b0000_0000};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'b0000_0000};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 8'b1010_0000};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 8'b0000_0000};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 8'b0001_0000};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 8'b0000_0000};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 8'b0100_0000};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 8'b0000_0000};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 8'b0001_0000};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 8'b0000_0000};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 8'b0000_1010};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hE, 8'b0000_1010};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 8'b1010_0000};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 8'b0000_0000};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 8'b0001_0000};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 8'b0000_0000};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 8'b0000_1100};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 8'b0000_1100};

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].r, vecs[i].ini, vecs[i].jog, vecs[i].fc, vecs[i].ig);
            checkOutput($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expOuts);
        end

        // Full correct round over 16 positions
        stepCheck("round_rst0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("round_rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cntRegistra = 0; cntConta = 0; cntZera = 0;
        stepCheck("round_ini", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        stepCheck("round_prep", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int p = 0; p < 16; p++) begin
            stepCheck("round_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            stepCheck("round_jog", 1'b1, 1'b0, 1'b1, p == 15, 1'b1);
            stepCheck("round_reg", 1'b1, 1'b0, 1'b0, p == 15, 1'b1);
            stepCheck("round_cmp", 1'b1, 1'b0, 1'b0, p == 15, 1'b1);
            if (p < 15) stepCheck("round_next", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("round_end", 4'hA, 8'b0000_1100);
        checkCount("round_registraR", cntRegistra, 16);
        checkCount("round_contaC", cntConta, 15);
        checkCount("round_zeraC", cntZera, 1);

        // Wrong play at position 3
        cntConta = 0;
        stepCheck("err_ini", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        stepCheck("err_prep", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int p = 0; p < 4; p++) begin
            stepCheck("err_jog", 1'b1, 1'b0, 1'b1, 1'b0, p != 3);
            stepCheck("err_reg", 1'b1, 1'b0, 1'b0, 1'b0, p != 3);
            stepCheck("err_cmp", 1'b1, 1'b0, 1'b0, 1'b0, p != 3);
            if (p < 3) stepCheck("err_next", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("err_end", 4'hE, 8'b0000_1010);
        checkCount("err_contaC", cntConta, 3);

        // Restart from the error state, then let the play window expire
        stepCheck("restart", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("restart_prep", 4'h1, 8'b1010_0000);
        stepCheck("to_enter", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        inWait = (bus.db_estado == 4'h2) ? 1 : 0;
        for (int c = 0; c < 20; c++) begin
            stepCheck("to_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            if (bus.db_estado == 4'h2) inWait++;
            else break;
        end
        checkCount("to_cycles", inWait, T);
        checkOutput("to_end", 4'hD, 8'b0000_1001);

        // A play edge in the last allowed cycle still counts
        stepCheck("late_ini", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        stepCheck("late_prep", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < T - 1; c++)
            stepCheck("late_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCheck("late_jog", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("late_edge_wins", 4'h3, 8'b0001_0000);
        stepCheck("late_reg", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCheck("late_cmp", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCheck("late_next", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // jogada held high for 20 cycles registers exactly one play
        cntRegistra = 0;
        for (int c = 0; c < 20; c++)
            stepCheck("held", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkCount("held_registraR", cntRegistra, 1);

        // Reset asserted while comparing aborts the round without contaC
        stepCheck("mid_ini", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        stepCheck("mid_prep", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCheck("mid_jog", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        stepCheck("mid_reg", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("mid_cmp", 4'h4, 8'b0000_0000);
        cntConta = 0;
        stepCheck("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("mid_rst_state", 4'h0, 8'b0000_0000);
        stepCheck("mid_rel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkCount("mid_contaC", cntConta, 0);

        // Randomised traffic against the round model
        for (int c = 0; c < 800; c++) begin
            stepCheck("rand",
                      logic'($urandom_range(0, 59) != 0),
                      logic'($urandom_range(0, 7) == 0),
                      logic'($urandom_range(0, 2) == 0),
                      logic'($urandom_range(0, 3) == 0),
                      logic'($urandom_range(0, 4) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
